// File: rtl/uart_sha256_client.sv
// UART SHA-256 host client: frames a message as 0x01/payload/0xFF, then decodes a 64-char hex digest.
// Define SHA_CLIENT_TIMEOUT_EN to enable the response watchdog.

module uart_tx_core #(parameter int unsigned BAUD_DIV = 868) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_busy,
   output logic       tx
);
   localparam logic [31:0] LAST = 32'(BAUD_DIV - 1);
   logic [9:0]  shift_q;
   logic [3:0]  bit_q;
   logic [31:0] baud_q;
   logic        busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '1;
         bit_q   <= '0;
         baud_q  <= '0;
         busy_q  <= 1'b0;
      end else if (!busy_q) begin
         if (tx_start) begin
            shift_q <= {1'b1, tx_data, 1'b0};
            bit_q   <= '0;
            baud_q  <= '0;
            busy_q  <= 1'b1;
         end
      end else if (baud_q == LAST) begin
         baud_q  <= '0;
         shift_q <= {1'b1, shift_q[9:1]};
         bit_q   <= bit_q + 4'd1;
         if (bit_q == 4'd9) busy_q <= 1'b0;
      end else begin
         baud_q <= baud_q + 32'd1;
      end
   end

   assign tx_busy = busy_q;
   assign tx      = busy_q ? shift_q[0] : 1'b1;
endmodule

module uart_rx_core #(parameter int unsigned BAUD_DIV = 868) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid
);
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
   localparam logic [31:0] FULL = 32'(BAUD_DIV - 1);
   localparam logic [31:0] HALF = 32'(BAUD_DIV / 2 - 1);
   rx_state_e   st_q;
   logic [1:0]  sync_q;
   logic [7:0]  data_q;
   logic [2:0]  bit_q;
   logic [31:0] baud_q;
   logic        valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q    <= RX_IDLE;
         sync_q  <= '1;
         data_q  <= '0;
         bit_q   <= '0;
         baud_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], rx};
         valid_q <= 1'b0;
         baud_q  <= baud_q + 32'd1;
         case (st_q)
            RX_IDLE: begin
               baud_q <= '0;
               if (!sync_q[1]) st_q <= RX_START;
            end
            // Re-check the start bit at its midpoint so later samples land mid-bit
            RX_START: if (baud_q == HALF) begin
               baud_q <= '0;
               bit_q  <= '0;
               st_q   <= sync_q[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (baud_q == FULL) begin
               baud_q <= '0;
               data_q <= {sync_q[1], data_q[7:1]};
               bit_q  <= bit_q + 3'd1;
               if (bit_q == 3'd7) st_q <= RX_STOP;
            end
            RX_STOP: if (baud_q == FULL) begin
               st_q    <= RX_IDLE;
               valid_q <= sync_q[1];
            end
            default: st_q <= RX_IDLE;
         endcase
      end
   end

   assign rx_data  = data_q;
   assign rx_valid = valid_q;
endmodule

module uart_sha256_client #(
   parameter int unsigned CLK_FREQ       = 100_000_000,
   parameter int unsigned BAUD           = 115200,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         uart_rx,
   output logic         uart_tx,
   input  logic         req_start,
   input  logic [7:0]   msg_data,
   input  logic         msg_valid,
   input  logic         msg_last,
   output logic         msg_ready,
   output logic         busy,
   output logic [255:0] digest,
   output logic         digest_valid,
   output logic         error,
   output logic         timeout
);
   localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
   typedef enum logic [2:0] {IDLE, SEND_START, SEND_DATA, SEND_END, RECV} state_e;

   state_e       state_q, state_d;
   logic         guard_q, guard_d, end_sent_q, end_sent_d;
   logic [5:0]   cnt_q, cnt_d;
   logic [255:0] shift_q, shift_d, digest_q, digest_d;
   logic         dv_q, dv_d, err_q, err_d, to_q, to_d;
   logic         tx_start, tx_busy, rx_valid, can_issue, is_hex;
   logic [7:0]   tx_data, rx_data;
   logic [3:0]   nib;
`ifdef SHA_CLIENT_TIMEOUT_EN
   logic [31:0]  wd_q, wd_d;
`else
   logic         unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   uart_tx_core #(.BAUD_DIV(BAUD_DIV)) u_tx (
      .clk(clk), .rst(~rst_n), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx(uart_tx));
   uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk(clk), .rst(~rst_n), .rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid));

   assign can_issue = !tx_busy && !guard_q;

   always_comb begin
      is_hex = 1'b1;
      nib    = '0;
      if (rx_data >= 8'h30 && rx_data <= 8'h39)      nib = 4'(rx_data - 8'h30);
      else if (rx_data >= 8'h61 && rx_data <= 8'h66) nib = 4'(rx_data - 8'h57);
      else if (rx_data >= 8'h41 && rx_data <= 8'h46) nib = 4'(rx_data - 8'h37);
      else                                           is_hex = 1'b0;
   end

   always_comb begin
      state_d    = state_q;
      guard_d    = guard_q;
      end_sent_d = end_sent_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      digest_d   = digest_q;
      dv_d       = 1'b0;
      err_d      = 1'b0;
      to_d       = 1'b0;
      tx_start   = 1'b0;
      tx_data    = 8'h01;
      msg_ready  = 1'b0;
`ifdef SHA_CLIENT_TIMEOUT_EN
      wd_d       = wd_q;
`endif
      // Guard covers the cycle between issuing a byte and the core raising tx_busy
      if (guard_q && tx_busy) guard_d = 1'b0;
      case (state_q)
         IDLE: if (req_start) state_d = SEND_START;
         SEND_START: if (can_issue) begin
            tx_start = 1'b1;
            guard_d  = 1'b1;
            state_d  = SEND_DATA;
         end
         SEND_DATA: begin
            msg_ready = can_issue;
            tx_data   = msg_data;
            if (can_issue && msg_valid) begin
               if (msg_data == 8'hFF) err_d = 1'b1;
               else begin
                  tx_start = 1'b1;
                  guard_d  = 1'b1;
               end
               if (msg_last) state_d = SEND_END;
            end
         end
         SEND_END: begin
            tx_data = 8'hFF;
            if (!end_sent_q) begin
               if (can_issue) begin
                  tx_start   = 1'b1;
                  guard_d    = 1'b1;
                  end_sent_d = 1'b1;
               end
            end else if (!guard_q) begin
               state_d    = RECV;
               end_sent_d = 1'b0;
               cnt_d      = '0;
               shift_d    = '0;
`ifdef SHA_CLIENT_TIMEOUT_EN
               wd_d       = '0;
`endif
            end
         end
         RECV: begin
            if (rx_valid) begin
`ifdef SHA_CLIENT_TIMEOUT_EN
               wd_d = '0;
`endif
               if (!is_hex) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  shift_d = {shift_q[251:0], nib};
                  cnt_d   = cnt_q + 6'd1;
                  if (cnt_q == 6'd63) begin
                     digest_d = {shift_q[251:0], nib};
                     dv_d     = 1'b1;
                     state_d  = IDLE;
                  end
               end
            end
`ifdef SHA_CLIENT_TIMEOUT_EN
            else if (wd_q == TIMEOUT_CYCLES - 32'd1) begin
               to_d    = 1'b1;
               state_d = IDLE;
            end else wd_d = wd_q + 32'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         guard_q    <= 1'b0;
         end_sent_q <= 1'b0;
         cnt_q      <= '0;
         shift_q    <= '0;
         digest_q   <= '0;
         dv_q       <= 1'b0;
         err_q      <= 1'b0;
         to_q       <= 1'b0;
`ifdef SHA_CLIENT_TIMEOUT_EN
         wd_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         guard_q    <= guard_d;
         end_sent_q <= end_sent_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         digest_q   <= digest_d;
         dv_q       <= dv_d;
         err_q      <= err_d;
         to_q       <= to_d;
`ifdef SHA_CLIENT_TIMEOUT_EN
         wd_q       <= wd_d;
`endif
      end
   end

   assign busy         = (state_q != IDLE);
   assign digest       = digest_q;
   assign digest_valid = dv_q;
   assign error        = err_q;
   assign timeout      = to_q;
endmodule

// File: tb/tb_uart_sha256_client.sv
// Scoreboard bench for uart_sha256_client: wire bytes, digests, error and timeout pulses checked by monitors.
`timescale 1ns/1ps
module tb_uart_sha256_client;
   localparam int unsigned D = 8;

   logic         clk = 1'b0, rst_n = 1'b0, uart_rx = 1'b1;
   logic         req_start = 1'b0, msg_valid = 1'b0, msg_last = 1'b0;
   logic [7:0]   msg_data = '0;
   logic         uart_tx, msg_ready, busy, digest_valid, error, timeout;
   logic [255:0] digest;

   int unsigned  n_checks = 0, n_pass = 0;
   logic [7:0]   wire_q[$];
   logic [255:0] dig_q[$];
   int unsigned  err_exp = 0, to_exp = 0;
   logic [255:0] model_digest = '0;

   always #5 clk = ~clk;

   uart_sha256_client #(.CLK_FREQ(800_000), .BAUD(100_000), .TIMEOUT_CYCLES(32'd1000)) dut (
      .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx), .uart_tx(uart_tx), .req_start(req_start),
      .msg_data(msg_data), .msg_valid(msg_valid), .msg_last(msg_last), .msg_ready(msg_ready),
      .busy(busy), .digest(digest), .digest_valid(digest_valid), .error(error), .timeout(timeout));

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic int hexval(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - int'("0");
      if (c >= "a" && c <= "f") return int'(c) - int'("a") + 10;
      if (c >= "A" && c <= "F") return int'(c) - int'("A") + 10;
      return -1;
   endfunction

   // Wire monitor: captures 10*D samples from a start edge, checks bit widths and decodes the byte
   initial begin
      logic [10*D-1:0] samp;
      logic [7:0]      b_v;
      logic            ok;
      forever begin
         @(negedge clk);
         if (rst_n && uart_tx == 1'b0) begin
            for (int i = 0; i < 10 * D; i++) begin
               samp[i] = uart_tx;
               if (i != 10 * D - 1) @(negedge clk);
            end
            ok = (samp[0] == 1'b0) && (samp[9*D] == 1'b1);
            for (int b = 0; b < 10; b++)
               for (int k = 0; k < D; k++)
                  if (samp[b*D+k] !== samp[b*D]) ok = 1'b0;
            for (int b = 0; b < 8; b++) b_v[b] = samp[(b+1)*D + D/2];
            check("frame_shape", ok, 1'b1);
            if (wire_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_wire_byte: got %h expected none", b_v);
            end else check("wire_byte", b_v, wire_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && digest_valid) begin
         if (dig_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_digest_valid: got %h expected no pulse", digest);
         end else check("digest", digest, dig_q.pop_front());
      end
      if (rst_n && error) begin
         check("error_expected", (err_exp != 0), 1'b1);
         if (err_exp != 0) err_exp--;
      end
      if (rst_n && timeout) begin
         check("timeout_expected", (to_exp != 0), 1'b1);
         if (to_exp != 0) to_exp--;
      end
   end

   task automatic send_char(input logic [7:0] c);
      logic [9:0] f;
      f = {1'b1, c, 1'b0};
      for (int b = 0; b < 10; b++) begin
         uart_rx = f[b];
         repeat (D) @(negedge clk);
      end
   endtask

   task automatic make_resp(input logic [255:0] v, input int casing, output logic [7:0] rs[$]);
      int n;
      bit up;
      rs = {};
      for (int i = 63; i >= 0; i--) begin
         n  = int'(v[i*4 +: 4]);
         up = (casing == 2) ? bit'($urandom_range(0, 1)) : (casing == 1);
         rs.push_back(n < 10 ? 8'(48 + n) : (up ? 8'(55 + n) : 8'(87 + n)));
      end
   endtask

   task automatic do_txn(input logic [7:0] pl[$], input logic [7:0] rs[$]);
      int unsigned  w;
      int           nv;
      int           cnt;
      bit           bad;
      logic [255:0] acc;
      wire_q.push_back(8'h01);
      foreach (pl[i]) begin
         if (pl[i] == 8'hFF) err_exp++;
         else wire_q.push_back(pl[i]);
      end
      wire_q.push_back(8'hFF);
      @(negedge clk);
      req_start = 1'b1;
      @(negedge clk);
      check("busy_after_req", busy, 1'b1);
      foreach (pl[i]) begin
         msg_valid = 1'b1;
         msg_data  = pl[i];
         msg_last  = (i == pl.size() - 1);
         w = 0;
         while (!msg_ready && w < 30 * D) begin
            @(negedge clk);
            w++;
         end
         check("msg_ready_wait", msg_ready, 1'b1);
         @(negedge clk);
      end
      msg_valid = 1'b0;
      msg_last  = 1'b0;
      req_start = 1'b0;
      w = 0;
      while (wire_q.size() != 0 && w < 40 * D) begin
         @(negedge clk);
         w++;
      end
      check("tx_drain", wire_q.size(), 0);
      check("busy_in_recv", busy, 1'b1);
      acc = '0;
      cnt = 0;
      bad = 1'b0;
      foreach (rs[i]) begin
         if (!bad) begin
            nv = hexval(rs[i]);
            if (nv < 0) begin
               bad = 1'b1;
               err_exp++;
            end else begin
               acc = acc * 16 + 256'(nv);
               cnt++;
            end
            send_char(rs[i]);
         end
      end
      if (cnt == 64) begin
         dig_q.push_back(acc);
         model_digest = acc;
      end
      if (cnt == 64 || bad) begin
         w = 0;
         while (busy && w < 30 * D) begin
            @(negedge clk);
            w++;
         end
         repeat (2) @(negedge clk);
         check("busy_end", busy, 1'b0);
         check("digest_hold", digest, model_digest);
         check("errors_seen", err_exp, 0);
         check("digests_seen", dig_q.size(), 0);
      end
   endtask

   task automatic rand_payload(output logic [7:0] pl[$]);
      int unsigned len;
      pl  = {};
      len = $urandom_range(1, 5);
      for (int i = 0; i < int'(len); i++)
         pl.push_back(($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
   endtask

   task automatic rand_digest(output logic [255:0] v);
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
   endtask

   initial begin
      logic [7:0]   pl[$];
      logic [7:0]   rs[$];
      logic [255:0] v;
      string        s;
      msg_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_uart_tx", uart_tx, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_digest", digest, '0);
      check("rst_digest_valid", digest_valid, 1'b0);
      check("rst_error", error, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_msg_ready", msg_ready, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_msg_ready", msg_ready, 1'b0);
      msg_valid = 1'b0;

      s  = "ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad";
      rs = {};
      for (int i = 0; i < s.len(); i++) rs.push_back(s[i]);
      pl = '{8'h61, 8'h62, 8'h63};
      do_txn(pl, rs);
      check("known_digest", model_digest,
            256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
      s  = s.toupper();
      rs = {};
      for (int i = 0; i < s.len(); i++) rs.push_back(s[i]);
      rand_payload(pl);
      do_txn(pl, rs);

      rand_digest(v);
      make_resp(v, 2, rs);
      pl = '{8'h10, 8'hFF, 8'h20};
      do_txn(pl, rs);

      rand_digest(v);
      make_resp(v, 0, rs);
      rs[9] = "g";
      rand_payload(pl);
      do_txn(pl, rs);

      for (int t = 0; t < 3; t++) begin
         rand_payload(pl);
         rand_digest(v);
         make_resp(v, t, rs);
         do_txn(pl, rs);
      end

      rand_digest(v);
      make_resp(v, 2, rs);
      rs = rs[0:4];
      rand_payload(pl);
      do_txn(pl, rs);
`ifdef SHA_CLIENT_TIMEOUT_EN
      to_exp++;
      repeat (1100) @(negedge clk);
      check("timeout_idle", busy, 1'b0);
      check("timeout_seen", to_exp, 0);
      check("timeout_digest", digest, model_digest);
`else
      repeat (10000) @(negedge clk);
      check("stall_busy", busy, 1'b1);
`endif
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("midrst_uart_tx", uart_tx, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_digest", digest, '0);
      check("midrst_msg_ready", msg_ready, 1'b0);
      model_digest = '0;
      err_exp = 0;
      to_exp  = 0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      rand_payload(pl);
      rand_digest(v);
      make_resp(v, 2, rs);
      do_txn(pl, rs);

      repeat (20) @(negedge clk);
      check("final_wire_q", wire_q.size(), 0);
      check("final_dig_q", dig_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: got no completion expected finish within bound");
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $fatal(1, "simulation time limit reached");
   end
endmodule
